stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages in each KEY synchronizer; legal values 2..3.
REQ-002 SHALL have parameter LIMIT_BCD, default 8'h59: two-digit BCD count at which the run terminates.
REQ-003 SHALL have port CLOCK_50  input  1  50 MHz system clock; all registers on its rising edge.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port KEY_start  input  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
REQ-006 SHALL have port KEY_stop  input  1  raw pushbutton, active-low, asynchronous.
REQ-007 SHALL have port KEY_lap  input  1  raw pushbutton, active-low, asynchronous; lap toggle / clear.
REQ-008 SHALL have port Tick  input  1  one-cycle 1 Hz pulse from the pulse generator, synchronous to CLOCK_50.
REQ-009 SHALL have port Q  input  8  current BCD count from the counter datapath ({tens, ones}).
REQ-010 SHALL have port PulseEn  output  1  enable to the pulse generator.
REQ-011 SHALL have port CountEn  output  1  qualified count enable to the counter datapath.
REQ-012 SHALL have port CountClr  output  1  synchronous clear to the counter datapath.
REQ-013 SHALL have port LapHold  output  1  display-freeze request.
REQ-014 SHALL have port Done  output  1  high while in DONE.
REQ-015 SHALL have port State  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 SHALL pass each KEY through a SYNC_STAGES flop synchronizer plus one history flop; press event = one-cycle pulse on a synchronized 1->0 transition.
REQ-017 With SYNC_STAGES=2, KEY first sampled low at edge k SHALL produce the FSM transition at edge k+2; a held key SHALL produce exactly one event.
REQ-018 IDLE: start event -> RUN; stop and lap events ignored.
REQ-019 RUN: stop event -> PAUSE; else Tick high with Q==LIMIT_BCD -> DONE; else lap event toggles LapHold, state unchanged.
REQ-020 PAUSE: start event -> RUN; else lap event -> IDLE; stop event ignored.
REQ-021 DONE: lap event -> IDLE; start and stop events ignored.
REQ-022 Same-cycle events SHALL be prioritised stop > start > lap; lower-priority events in that cycle are discarded.
REQ-023 PulseEn SHALL be registered and equal 1 exactly while State==RUN.
REQ-024 CountEn SHALL be combinational = Tick & (State==RUN) & ~stop_event & (Q!=LIMIT_BCD); zero latency from Tick.
REQ-025 A Tick coinciding with a stop event SHALL be dropped (no count).
REQ-026 The terminating Tick (Q==LIMIT_BCD) SHALL NOT assert CountEn; Q remains at LIMIT_BCD in DONE.
REQ-027 CountClr SHALL be a registered one-cycle pulse, high in the cycle after any transition into IDLE.
REQ-028 LapHold SHALL clear to 0 on every transition out of RUN other than RUN->PAUSE; it SHALL hold its value through PAUSE.
REQ-029 Done SHALL be registered and equal 1 exactly while State==DONE.

Reset
REQ-030 Resetn low SHALL immediately force State=IDLE, PulseEn=0, LapHold=0, Done=0, CountClr=1, and all synchronizer/history flops to 1 (released).
REQ-031 CountClr SHALL fall at the first CLOCK_50 edge after Resetn rises; a key held low through reset release SHALL produce one event after synchronization.
REQ-032 Reset asserted mid-RUN SHALL abort the run with no further CountEn pulses.

Verification
REQ-033 Reset release, press start at edge k -> State=01 and PulseEn=1 after edge k+2; CountClr high for exactly one cycle after release.
REQ-034 RUN, Q=8'h12, Tick pulse -> CountEn high in that same cycle; stop event on the same cycle as a later Tick -> CountEn=0, State=10.
REQ-035 RUN, Q=8'h59, Tick -> CountEn=0, State=11, Done=1; start press then ignored; lap press -> State=00, CountClr one-cycle pulse.
REQ-036 RUN, lap press twice -> LapHold 0->1->0; lap press, stop press -> PAUSE with LapHold=1; lap press -> IDLE, LapHold=0, CountClr pulse.
REQ-037 start and stop pressed within the same cycle from RUN -> PAUSE; key held low 1000 cycles -> single event only.
REQ-038 Resetn pulsed low mid-RUN with Tick active -> all outputs at reset values asynchronously, no CountEn until the next start event.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronizes and edge-detects the three active-low
// pushbuttons, sequences IDLE/RUN/PAUSE/DONE, and drives the pulse-generator
// and counter-datapath controls plus the lap display freeze.
module stopwatch_ctrl #(
  parameter int         SYNC_STAGES = 2,      // 2..3 flops per key synchronizer
  parameter logic [7:0] LIMIT_BCD   = 8'h59   // BCD count that ends the run
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       KEY_start,
  input  logic       KEY_stop,
  input  logic       KEY_lap,
  input  logic       Tick,
  input  logic [7:0] Q,
  output logic       PulseEn,
  output logic       CountEn,
  output logic       CountClr,
  output logic       LapHold,
  output logic       Done,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Key bit order everywhere: [0]=start, [1]=stop, [2]=lap
  logic [2:0]                  key_raw_s;
  logic [2:0][SYNC_STAGES-1:0] sync_r;
  logic [2:0]                  hist_r;
  logic [2:0]                  key_sync_s;
  logic [2:0]                  press_s;

  logic   start_ev_s;
  logic   stop_ev_s;
  logic   lap_ev_s;
  logic   at_limit_s;

  state_t state_r;
  state_t state_nxt_s;
  logic   lap_hold_nxt_s;
  logic   pulse_en_r;
  logic   count_clr_r;
  logic   lap_hold_r;
  logic   done_r;

  assign key_raw_s = {KEY_lap, KEY_stop, KEY_start};

  // Pick the last synchronizer stage of each key as its synchronized level
  always_comb begin
    key_sync_s = 3'b111;
    for (int i = 0; i < 3; i++) begin
      key_sync_s[i] = sync_r[i][SYNC_STAGES-1];
    end
  end

  // Key synchronizers and history flops; reset to the released (high) level
  // so a key held through reset still yields one press after release
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync_r <= '1;
      hist_r <= 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], key_raw_s[i]};
      end
      hist_r <= key_sync_s;
    end
  end

  // Press = synchronized 1->0 transition; same-cycle priority stop > start > lap
  always_comb begin
    press_s    = hist_r & ~key_sync_s;
    stop_ev_s  = press_s[1];
    start_ev_s = press_s[0] & ~press_s[1];
    lap_ev_s   = press_s[2] & ~press_s[1] & ~press_s[0];
    at_limit_s = (Q == LIMIT_BCD);
  end

  // Next state and next lap-hold value
  always_comb begin
    state_nxt_s    = state_r;
    lap_hold_nxt_s = lap_hold_r;
    case (state_r)
      ST_IDLE: begin
        lap_hold_nxt_s = 1'b0;
        if (start_ev_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_ev_s) begin
          state_nxt_s    = ST_PAUSE;      // freeze request survives the pause
          lap_hold_nxt_s = lap_hold_r;
        end else if (Tick && at_limit_s) begin
          state_nxt_s    = ST_DONE;
          lap_hold_nxt_s = 1'b0;
        end else if (lap_ev_s) begin
          state_nxt_s    = ST_RUN;
          lap_hold_nxt_s = ~lap_hold_r;
        end else begin
          state_nxt_s    = ST_RUN;
          lap_hold_nxt_s = lap_hold_r;
        end
      end
      ST_PAUSE: begin
        if (start_ev_s) begin
          state_nxt_s    = ST_RUN;
          lap_hold_nxt_s = lap_hold_r;
        end else if (lap_ev_s) begin
          state_nxt_s    = ST_IDLE;
          lap_hold_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = ST_PAUSE;
          lap_hold_nxt_s = lap_hold_r;
        end
      end
      ST_DONE: begin
        lap_hold_nxt_s = 1'b0;
        if (lap_ev_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        lap_hold_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs, all decoded from the next state
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= ST_IDLE;
      pulse_en_r  <= 1'b0;
      count_clr_r <= 1'b1;
      lap_hold_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pulse_en_r  <= (state_nxt_s == ST_RUN);
      count_clr_r <= (state_nxt_s == ST_IDLE) && (state_r != ST_IDLE);
      lap_hold_r  <= lap_hold_nxt_s;
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  // Zero-latency qualified count enable: a Tick is dropped on a stop press
  // and the terminating Tick at the limit never counts
  assign CountEn  = Tick & (state_r == ST_RUN) & ~stop_ev_s & ~at_limit_s;

  assign PulseEn  = pulse_en_r;
  assign CountClr = count_clr_r;
  assign LapHold  = lap_hold_r;
  assign Done     = done_r;
  assign State    = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b1;
  logic       KEY_start = 1'b1;
  logic       KEY_stop  = 1'b1;
  logic       KEY_lap   = 1'b1;
  logic       Tick      = 1'b0;
  logic [7:0] Q         = 8'h00;
  logic       PulseEn;
  logic       CountEn;
  logic       CountClr;
  logic       LapHold;
  logic       Done;
  logic [1:0] State;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.SYNC_STAGES(2), .LIMIT_BCD(8'h59)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .KEY_start(KEY_start),
    .KEY_stop (KEY_stop),
    .KEY_lap  (KEY_lap),
    .Tick     (Tick),
    .Q        (Q),
    .PulseEn  (PulseEn),
    .CountEn  (CountEn),
    .CountClr (CountClr),
    .LapHold  (LapHold),
    .Done     (Done),
    .State    (State)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  // keys = {lap, stop, start}; pressed keys go low, sampled at edge k, and the
  // FSM moves at edge k+2. Optionally raise Tick in the cycle the event is live.
  task automatic press(input logic [2:0] keys, input logic tick_on,
                       input logic exp_cnt, input string tag);
    {KEY_lap, KEY_stop, KEY_start} = ~keys;
    step();
    step();
    {KEY_lap, KEY_stop, KEY_start} = 3'b111;
    Tick = tick_on;
    #1;
    if (tick_on) check_eq(tag, {7'd0, CountEn}, {7'd0, exp_cnt});
    step();
    Tick = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic pe,
                            input logic clr, input logic lh, input logic dn);
    check_eq({tag, "_state"}, {6'd0, State}, {6'd0, st});
    check_eq({tag, "_pulse"}, {7'd0, PulseEn}, {7'd0, pe});
    check_eq({tag, "_clr"},   {7'd0, CountClr}, {7'd0, clr});
    check_eq({tag, "_lap"},   {7'd0, LapHold}, {7'd0, lh});
    check_eq({tag, "_done"},  {7'd0, Done}, {7'd0, dn});
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 Resetn = 1'b0;
    #3;
    check_outs("rst", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rst_cnt", {7'd0, CountEn}, 8'd0);
    step();
    Resetn = 1'b1;
    #1;
    check_eq("clr_held", {7'd0, CountClr}, 8'd1);
    step();
    check_eq("clr_fall", {7'd0, CountClr}, 8'd0);
    settle(2);

    // Start -> RUN
    press(3'b001, 1'b0, 1'b0, "p_start");
    check_outs("run", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    settle(2);

    // Tick at Q=12 counts in the same cycle
    Q = 8'h12; Tick = 1'b1; #1;
    check_eq("cnt_12", {7'd0, CountEn}, 8'd1);
    step();
    Tick = 1'b0; #1;
    check_eq("cnt_off", {7'd0, CountEn}, 8'd0);
    settle(2);

    // Stop coinciding with Tick: tick dropped, PAUSE
    press(3'b010, 1'b1, 1'b0, "cnt_stop");
    check_outs("pause", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    settle(2);

    // Resume, then terminating Tick at the limit
    press(3'b001, 1'b0, 1'b0, "p_resume");
    check_eq("resume_st", {6'd0, State}, 8'h01);
    settle(2);
    Q = 8'h59; Tick = 1'b1; #1;
    check_eq("cnt_lim", {7'd0, CountEn}, 8'd0);
    step();
    Tick = 1'b0;
    check_outs("done", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    settle(2);
    press(3'b001, 1'b0, 1'b0, "p_done_start");
    check_eq("done_start", {6'd0, State}, 8'h03);
    settle(2);
    press(3'b010, 1'b0, 1'b0, "p_done_stop");
    check_eq("done_stop", {6'd0, State}, 8'h03);
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_done_lap");
    check_outs("done_lap", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("clr_pulse1", {7'd0, CountClr}, 8'd0);
    settle(2);

    // Stop and lap in IDLE are ignored; staying in IDLE gives no clear pulse
    press(3'b010, 1'b0, 1'b0, "p_idle_stop");
    check_eq("idle_stop", {6'd0, State}, 8'h00);
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_idle_lap");
    check_outs("idle_lap", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    settle(2);

    // Lap toggling in RUN, hold through PAUSE, clear on exit to IDLE
    Q = 8'h00;
    press(3'b001, 1'b0, 1'b0, "p_start2");
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_lap1");
    check_eq("lap1", {7'd0, LapHold}, 8'd1);
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_lap2");
    check_eq("lap2", {7'd0, LapHold}, 8'd0);
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_lap3");
    settle(2);
    press(3'b010, 1'b0, 1'b0, "p_stop_lap");
    check_outs("pause_lap", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    settle(2);
    press(3'b100, 1'b0, 1'b0, "p_pause_lap");
    check_outs("pause_idle", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    settle(2);

    // Start and stop in the same cycle from RUN -> PAUSE
    press(3'b001, 1'b0, 1'b0, "p_start3");
    settle(2);
    press(3'b011, 1'b0, 1'b0, "p_both");
    check_eq("both_st", {6'd0, State}, 8'h02);
    settle(2);

    // Lap held 1000 cycles toggles exactly once
    press(3'b001, 1'b0, 1'b0, "p_start4");
    settle(2);
    KEY_lap = 1'b0;
    settle(1000);
    check_eq("lap_held", {7'd0, LapHold}, 8'd1);
    KEY_lap = 1'b1;
    settle(4);
    check_eq("lap_held2", {7'd0, LapHold}, 8'd1);

    // Reset mid-RUN with Tick active
    Q = 8'h30; Tick = 1'b1; #1;
    check_eq("pre_rst_cnt", {7'd0, CountEn}, 8'd1);
    #3 Resetn = 1'b0;
    #1;
    check_outs("mid_rst", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mid_rst_cnt", {7'd0, CountEn}, 8'd0);
    settle(3);
    Resetn = 1'b1;
    step();
    check_eq("post_rst_cnt", {7'd0, CountEn}, 8'd0);
    check_eq("post_rst_clr", {7'd0, CountClr}, 8'd0);
    settle(3);
    check_eq("post_rst_cnt2", {7'd0, CountEn}, 8'd0);
    Tick = 1'b0;

    // Key held low through reset release yields one start event at edge 3
    Resetn = 1'b0;
    KEY_start = 1'b0;
    step();
    Resetn = 1'b1;
    step();
    step();
    check_eq("held_k2", {6'd0, State}, 8'h00);
    step();
    check_eq("held_k3", {6'd0, State}, 8'h01);
    settle(20);
    KEY_start = 1'b1;
    settle(3);
    check_outs("held_end", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
